// File: rtl/prbs31_checker.sv
// prbs31_checker: receive-side PRBS31 (x^31 + x^28 + 1) checker.
// In SEARCH the shift register loads received bits until LOCK_CNT consecutive
// predictions hit. In LOCKED it free-runs on its own prediction, so a line
// error is counted once rather than multiplied. Too many errors inside one
// observation window forces a return to SEARCH.
// Optional feature macro: PRBS31_BIT_CNT_EN adds the 32-bit bit_cnt output
// (valid bits seen while locked). Without it the port and counter are absent.
module prbs31_checker #(
  parameter int LOCK_CNT    = 31,
  parameter int WIN_LEN     = 64,
  parameter int LOSS_THRESH = 8,
  parameter int ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_vld,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
`ifdef PRBS31_BIT_CNT_EN
  output logic [31:0]      bit_cnt,
`endif
  output logic [ERR_W-1:0] err_cnt
);

  localparam int WIN_W  = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int WERR_W = (LOSS_THRESH > 1) ? $clog2(LOSS_THRESH + 1) : 1;

  localparam logic [7:0]        MATCH_LAST = 8'(LOCK_CNT - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST   = WIN_W'(WIN_LEN - 1);
  localparam logic [WERR_W-1:0] ERR_LAST   = WERR_W'(LOSS_THRESH - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX    = {ERR_W{1'b1}};

  typedef enum logic [0:0] {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Next PRBS31 bit predicted from the last 31 bits (taps 28 and 31).
  function automatic logic prbs_pred(input logic [30:0] s);
    return s[27] ^ s[30];
  endfunction

  state_t              state_r;
  state_t              state_nxt_s;
  logic                locked_r;
  logic [30:0]         sr_r;
  logic [7:0]          match_cnt_r;
  logic [WIN_W-1:0]    win_cnt_r;
  logic [WERR_W-1:0]   win_err_r;
  logic [ERR_W-1:0]    err_cnt_r;
  logic                err_pulse_r;

  logic                pred_s;
  logic                mism_s;
  logic                sr_zero_s;
  logic                win_last_s;
  logic                lock_hit_s;
  logic                loss_hit_s;

  logic                shift_bit_s;
  logic                search_upd_s;
  logic                locked_upd_s;
  logic                count_err_s;

  assign pred_s     = prbs_pred(sr_r);
  assign mism_s     = bit_vld & (bit_in ^ pred_s);
  assign sr_zero_s  = (sr_r == 31'd0);
  assign win_last_s = (win_cnt_r == WIN_LAST);

  // The LOCK_CNT-th consecutive good bit; an all-zero register never counts.
  assign lock_hit_s = (state_r == ST_SEARCH) & bit_vld & ~sr_zero_s & ~mism_s &
                      (match_cnt_r == MATCH_LAST);

  // This error brings the window error count up to LOSS_THRESH.
  assign loss_hit_s = (state_r == ST_LOCKED) & mism_s & (win_err_r == ERR_LAST);

  assign count_err_s = locked_upd_s & mism_s;

  // State register; locked is registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_SEARCH;
      locked_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      locked_r <= (state_nxt_s == ST_LOCKED);
    end
  end

  // Next-state logic: acquire on a full run of matches, drop on an error burst.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_SEARCH: begin
        if (lock_hit_s) begin
          state_nxt_s = ST_LOCKED;
        end else begin
          state_nxt_s = ST_SEARCH;
        end
      end
      ST_LOCKED: begin
        if (loss_hit_s) begin
          state_nxt_s = ST_SEARCH;
        end else begin
          state_nxt_s = ST_LOCKED;
        end
      end
      default: state_nxt_s = ST_SEARCH;
    endcase
  end

  // Per-state datapath controls: shift source and which counters update.
  always_comb begin
    shift_bit_s  = bit_in;
    search_upd_s = 1'b0;
    locked_upd_s = 1'b0;
    case (state_r)
      ST_SEARCH: begin
        shift_bit_s  = bit_in;
        search_upd_s = bit_vld;
      end
      ST_LOCKED: begin
        shift_bit_s  = pred_s;
        locked_upd_s = bit_vld;
      end
      default: begin
        shift_bit_s  = bit_in;
        search_upd_s = 1'b0;
        locked_upd_s = 1'b0;
      end
    endcase
  end

  // Reference shift register: received data in SEARCH, own prediction in LOCKED.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_r <= 31'd0;
    end else if (bit_vld) begin
      sr_r <= {sr_r[29:0], shift_bit_s};
    end else begin
      sr_r <= sr_r;
    end
  end

  // Consecutive-match counter used only for acquisition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt_r <= 8'd0;
    end else if (search_upd_s) begin
      if (sr_zero_s || mism_s || lock_hit_s) begin
        match_cnt_r <= 8'd0;
      end else begin
        match_cnt_r <= match_cnt_r + 8'd1;
      end
    end else if (loss_hit_s) begin
      match_cnt_r <= 8'd0;
    end else begin
      match_cnt_r <= match_cnt_r;
    end
  end

  // Loss-of-lock window: bit position and error tally within the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_r <= {WIN_W{1'b0}};
      win_err_r <= {WERR_W{1'b0}};
    end else if (locked_upd_s) begin
      if (loss_hit_s || win_last_s) begin
        win_cnt_r <= {WIN_W{1'b0}};
        win_err_r <= {WERR_W{1'b0}};
      end else begin
        win_cnt_r <= win_cnt_r + WIN_W'(1);
        win_err_r <= win_err_r + (mism_s ? WERR_W'(1) : WERR_W'(0));
      end
    end else begin
      win_cnt_r <= win_cnt_r;
      win_err_r <= win_err_r;
    end
  end

  // Saturating error counter; a clear request beats a same-cycle error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_r <= {ERR_W{1'b0}};
    end else if (clr_cnt) begin
      err_cnt_r <= {ERR_W{1'b0}};
    end else if (count_err_s && (err_cnt_r != ERR_MAX)) begin
      err_cnt_r <= err_cnt_r + ERR_W'(1);
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  // One-cycle error strobe for each errored bit seen while locked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse_r <= 1'b0;
    end else begin
      err_pulse_r <= count_err_s;
    end
  end

`ifdef PRBS31_BIT_CNT_EN
  logic [31:0] bit_cnt_r;

  // Saturating count of valid bits checked while locked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_r <= 32'd0;
    end else if (clr_cnt) begin
      bit_cnt_r <= 32'd0;
    end else if (locked_upd_s && (bit_cnt_r != 32'hFFFF_FFFF)) begin
      bit_cnt_r <= bit_cnt_r + 32'd1;
    end else begin
      bit_cnt_r <= bit_cnt_r;
    end
  end

  assign bit_cnt = bit_cnt_r;
`endif

  assign locked    = locked_r;
  assign err_pulse = err_pulse_r;
  assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_prbs31_checker.sv
// Testbench for prbs31_checker. Two instances share one stimulus stream:
// dut_a with the default 16-bit error counter and dut_b with a 4-bit one.
module tb_prbs31_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bit_in = 1'b0;
  logic        bit_vld = 1'b0;
  logic        clr_cnt = 1'b0;
  logic        locked_a, err_pulse_a;
  logic [15:0] err_cnt_a;
  logic        locked_b, err_pulse_b;
  logic [3:0]  err_cnt_b;
`ifdef PRBS31_BIT_CNT_EN
  logic [31:0] bit_cnt_a, bit_cnt_b;
`endif

  prbs31_checker dut_a (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_vld(bit_vld),
    .clr_cnt(clr_cnt), .locked(locked_a), .err_pulse(err_pulse_a),
`ifdef PRBS31_BIT_CNT_EN
    .bit_cnt(bit_cnt_a),
`endif
    .err_cnt(err_cnt_a)
  );

  prbs31_checker #(.ERR_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_vld(bit_vld),
    .clr_cnt(clr_cnt), .locked(locked_b), .err_pulse(err_pulse_b),
`ifdef PRBS31_BIT_CNT_EN
    .bit_cnt(bit_cnt_b),
`endif
    .err_cnt(err_cnt_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        pulse;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad = 0;
  logic [30:0] gen = 31'd1;
  int          exp_a = 0;
  int          exp_b = 0;
  int          vcnt = 0;
  int          first_one = -1;
  int          lk_bits = 0;
  int          lock_pt_clean = 0;

  // Drive one cycle of stimulus, queue the expected result, then check it.
  // Tests invert bits only while the checker is locked, so every inverted
  // valid bit is expected to produce an error pulse.
  task automatic drive_bit(input logic inv, input logic vld, input logic clr);
    logic g;
    logic was_locked;
    exp_t e;
    if (vld) begin
      g = gen[27] ^ gen[30];
      gen = {gen[29:0], g};
      bit_in = g ^ inv;
      vcnt++;
      if (g && first_one < 0) first_one = vcnt;
    end else begin
      bit_in = 1'($urandom_range(0, 1));
    end
    bit_vld = vld;
    clr_cnt = clr;
    if (clr) begin
      exp_a = 0;
      exp_b = 0;
    end else if (vld && inv) begin
      if (exp_a < 65535) exp_a++;
      if (exp_b < 15) exp_b++;
    end
    e.pulse = vld & inv;
    e.cnt_a = 16'(exp_a);
    e.cnt_b = 4'(exp_b);
    sb_q.push_back(e);
    was_locked = locked_a;
    @(posedge clk);
    #1;
    if (vld) lk_bits = (was_locked === 1'b1) ? lk_bits + 1 : 0;
    e = sb_q.pop_front();
    total++;
    if (err_pulse_a !== e.pulse) begin
      bad++;
      $display("FAIL err_pulse_a got=%0b want=%0b t=%0t", err_pulse_a, e.pulse, $time);
    end
    total++;
    if (err_pulse_b !== e.pulse) begin
      bad++;
      $display("FAIL err_pulse_b got=%0b want=%0b t=%0t", err_pulse_b, e.pulse, $time);
    end
    total++;
    if (err_cnt_a !== e.cnt_a) begin
      bad++;
      $display("FAIL err_cnt_a got=%0d want=%0d t=%0t", err_cnt_a, e.cnt_a, $time);
    end
    total++;
    if (err_cnt_b !== e.cnt_b) begin
      bad++;
      $display("FAIL err_cnt_b got=%0d want=%0d t=%0t", err_cnt_b, e.cnt_b, $time);
    end
  endtask

  // Feed clean bits (optionally with idle gaps) until lock or cycle budget.
  task automatic run_until_lock(input int max_cyc, input bit gaps,
                                output int nvalid, output bit ok);
    logic v;
    nvalid = 0;
    ok = 1'b0;
    for (int c = 0; c < max_cyc && !ok; c++) begin
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      drive_bit(1'b0, v, 1'b0);
      if (v) nvalid++;
      if (locked_a === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (locked_a !== 1'b0 || locked_b !== 1'b0) begin
      bad++;
      $display("FAIL reset_locked got=%0b/%0b want=0", locked_a, locked_b);
    end
    total++;
    if (err_pulse_a !== 1'b0 || err_pulse_b !== 1'b0) begin
      bad++;
      $display("FAIL reset_pulse got=%0b/%0b want=0", err_pulse_a, err_pulse_b);
    end
    total++;
    if (err_cnt_a !== 16'd0 || err_cnt_b !== 4'd0) begin
      bad++;
      $display("FAIL reset_cnt got=%0d/%0d want=0", err_cnt_a, err_cnt_b);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_all_zero();
    bit seen = 1'b0;
    gen = 31'd0;
    for (int i = 0; i < 300; i++) begin
      drive_bit(1'b0, 1'b1, 1'b0);
      if (locked_a !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL all_zero_lock got=%0b want=0", seen);
    end
  endtask

  task automatic test_clean_lock();
    int  n;
    bit  ok;
    gen = 31'd1;
    vcnt = 0;
    first_one = -1;
    run_until_lock(200, 1'b0, n, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL clean_lock got=unlocked want=locked after %0d bits", n);
    end
    total++;
    if (ok && (first_one < 0 || n - first_one > 70)) begin
      bad++;
      $display("FAIL clean_lock_latency got=%0d want<=70", n - first_one);
    end
    lock_pt_clean = n;
    for (int i = n; i < 200; i++) drive_bit(1'b0, 1'b1, 1'b0);
    total++;
    if (locked_a !== 1'b1) begin
      bad++;
      $display("FAIL clean_hold got=%0b want=1", locked_a);
    end
  endtask

  task automatic test_single_error();
    drive_bit(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) drive_bit(1'b0, 1'b1, 1'b0);
    total++;
    if (locked_a !== 1'b1) begin
      bad++;
      $display("FAIL single_locked got=%0b want=1", locked_a);
    end
  endtask

  task automatic test_burst();
    int n;
    bit ok;
    for (int k = 0; k < 64 && (lk_bits % 64) != 2; k++) drive_bit(1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      drive_bit(1'b1, 1'b1, 1'b0);
      if (i == 7) begin
        total++;
        if (locked_a !== 1'b1) begin
          bad++;
          $display("FAIL burst_hold7 got=%0b want=1", locked_a);
        end
      end
    end
    total++;
    if (locked_a !== 1'b0 || locked_b !== 1'b0) begin
      bad++;
      $display("FAIL burst_drop got=%0b/%0b want=0", locked_a, locked_b);
    end
    run_until_lock(62, 1'b0, n, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL burst_relock got=unlocked want=locked within 62 bits");
    end
  endtask

  task automatic test_async_reset();
    int n;
    bit ok;
    total++;
    if (locked_a !== 1'b1 || err_cnt_a === 16'd0) begin
      bad++;
      $display("FAIL areset_pre got=%0b/%0d want=1/nonzero", locked_a, err_cnt_a);
    end
    bit_vld = 1'b0;
    clr_cnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (locked_a !== 1'b0 || locked_b !== 1'b0) begin
      bad++;
      $display("FAIL areset_locked got=%0b/%0b want=0", locked_a, locked_b);
    end
    total++;
    if (err_cnt_a !== 16'd0 || err_cnt_b !== 4'd0 || err_pulse_a !== 1'b0) begin
      bad++;
      $display("FAIL areset_cnt got=%0d/%0d/%0b want=0/0/0", err_cnt_a, err_cnt_b, err_pulse_a);
    end
    exp_a = 0;
    exp_b = 0;
    #1 rst_n = 1'b1;
    run_until_lock(100, 1'b0, n, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL areset_relock got=unlocked want=locked within 100 bits");
    end
  endtask

  task automatic test_saturation();
    bit dropped = 1'b0;
    drive_bit(1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 200; i++) begin
      drive_bit((i % 10) == 0, 1'b1, 1'b0);
      if (locked_a !== 1'b1) dropped = 1'b1;
    end
    total++;
    if (dropped !== 1'b0) begin
      bad++;
      $display("FAIL sat_lock got=dropped want=held");
    end
    total++;
    if (err_cnt_b !== 4'd15) begin
      bad++;
      $display("FAIL sat_cnt_b got=%0d want=15", err_cnt_b);
    end
    total++;
    if (err_cnt_a !== 16'd20) begin
      bad++;
      $display("FAIL sat_cnt_a got=%0d want=20", err_cnt_a);
    end
    for (int i = 0; i < 64; i++) drive_bit(1'b0, 1'b1, 1'b0);
    drive_bit(1'b1, 1'b1, 1'b1);
    total++;
    if (err_cnt_a !== 16'd0 || err_cnt_b !== 4'd0 || err_pulse_a !== 1'b1) begin
      bad++;
      $display("FAIL clr_vs_err got=%0d/%0d/%0b want=0/0/1", err_cnt_a, err_cnt_b, err_pulse_a);
    end
  endtask

  task automatic test_gaps();
    int n;
    bit ok;
    bit_vld = 1'b0;
    clr_cnt = 1'b0;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    exp_a = 0;
    exp_b = 0;
    gen = 31'd1;
    run_until_lock(1000, 1'b1, n, ok);
    total++;
    if (!ok || n !== lock_pt_clean) begin
      bad++;
      $display("FAIL gaps_lock_point got=%0d want=%0d", n, lock_pt_clean);
    end
    for (int i = 0; i < 50; i++) drive_bit(1'b0, ($urandom_range(0, 1) != 0), 1'b0);
    total++;
    if (locked_a !== 1'b1) begin
      bad++;
      $display("FAIL gaps_hold got=%0b want=1", locked_a);
    end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_clean_lock();
    test_single_error();
    test_burst();
    test_async_reset();
    test_saturation();
    test_gaps();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
